// File: rtl/approx_eval_pkg.sv
// Shared types and helpers for the approximate-circuit evaluation harnesses.
package approx_eval_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StSweep = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned DefOpBits = 2;
    localparam int unsigned DefEt     = 3;

    // Unsigned magnitude of x - y; callers zero-extend into and truncate out of 32 bits.
    function automatic logic [31:0] abs_diff(input logic [31:0] x, input logic [31:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/exact_adder_ref.sv
// Combinational exact-sum reference and absolute error against the DUT output.
module exact_adder_ref
    import approx_eval_pkg::*;
#(
    parameter int unsigned OP_BITS  = DefOpBits,
    parameter int unsigned OUT_BITS = OP_BITS + 1
) (
    input  logic [OP_BITS-1:0]  a_i,
    input  logic [OP_BITS-1:0]  b_i,
    input  logic [OUT_BITS-1:0] dut_i,
    output logic [OUT_BITS-1:0] err_o
);

    logic [OUT_BITS-1:0] exact;

    always_comb begin
        exact = OUT_BITS'(a_i) + OUT_BITS'(b_i);
        err_o = OUT_BITS'(abs_diff(32'(exact), 32'(dut_i)));
    end

endmodule

// File: rtl/approx_adder_et_checker.sv
// Exhaustive sweep of a combinational approximate adder, scoring error statistics
// against an error threshold.
module approx_adder_et_checker
    import approx_eval_pkg::*;
#(
    parameter int unsigned OP_BITS  = DefOpBits,
    parameter int unsigned IN_BITS  = 2 * OP_BITS,
    parameter int unsigned OUT_BITS = OP_BITS + 1,
    parameter int unsigned ET       = DefEt
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [IN_BITS-1:0]          stim,
    input  logic [OUT_BITS-1:0]         dut_out,
    output logic                        busy,
    output logic                        done,
    output logic                        pass,
    output logic [OUT_BITS-1:0]         max_err,
    output logic [IN_BITS:0]            err_count,
    output logic [IN_BITS+OUT_BITS-1:0] err_sum,
    output logic                        fail_valid,
    output logic [IN_BITS-1:0]          fail_vec
);

    localparam logic [IN_BITS-1:0] LastIdx = '1;

    state_e                      state_q, state_d;
    logic [IN_BITS-1:0]          idx_q, idx_d;
    logic [OUT_BITS-1:0]         max_err_q, max_err_d;
    logic [IN_BITS:0]            cnt_q, cnt_d;
    logic [IN_BITS+OUT_BITS-1:0] sum_q, sum_d;
    logic                        fail_valid_q, fail_valid_d;
    logic [IN_BITS-1:0]          fail_vec_q, fail_vec_d;
    logic                        done_q, done_d;
    logic                        pass_q, pass_d;
    logic [OUT_BITS-1:0]         err;
    logic                        arm;

    exact_adder_ref #(
        .OP_BITS (OP_BITS),
        .OUT_BITS(OUT_BITS)
    ) u_ref (
        .a_i  (idx_q[OP_BITS-1:0]),
        .b_i  (idx_q[IN_BITS-1:OP_BITS]),
        .dut_i(dut_out),
        .err_o(err)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        max_err_d    = max_err_q;
        cnt_d        = cnt_q;
        sum_d        = sum_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        done_d       = 1'b0;
        pass_d       = pass_q;
        arm          = 1'b0;

        unique case (state_q)
            StIdle: begin
                arm = start;
            end
            StSweep: begin
                max_err_d = (err > max_err_q) ? err : max_err_q;
                if (err != '0) begin
                    cnt_d = cnt_q + (IN_BITS + 1)'(1);
                end
                sum_d = sum_q + (IN_BITS + OUT_BITS)'(err);
                if ((32'(err) > ET) && !fail_valid_q) begin
                    fail_valid_d = 1'b1;
                    fail_vec_d   = idx_q;
                end
                // The last vector stays on stim through DONE instead of wrapping.
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    pass_d  = (32'(max_err_d) <= ET);
                end else begin
                    idx_d = idx_q + IN_BITS'(1);
                end
            end
            StDone: begin
                arm = start;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (arm) begin
            state_d      = StSweep;
            idx_d        = '0;
            max_err_d    = '0;
            cnt_d        = '0;
            sum_d        = '0;
            fail_valid_d = 1'b0;
            fail_vec_d   = '0;
            pass_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            max_err_q    <= '0;
            cnt_q        <= '0;
            sum_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            max_err_q    <= max_err_d;
            cnt_q        <= cnt_d;
            sum_q        <= sum_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
        end
    end

    assign stim       = idx_q;
    assign busy       = (state_q == StSweep);
    assign done       = done_q;
    assign pass       = pass_q;
    assign max_err    = max_err_q;
    assign err_count  = cnt_q;
    assign err_sum    = sum_q;
    assign fail_valid = fail_valid_q;
    assign fail_vec   = fail_vec_q;

endmodule

// File: tb/tb_approx_adder_et_checker.sv
// Bench: two checkers (ET=3 and ET=2) sweep the same lookup-table DUT model.
module tb_approx_adder_et_checker;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    logic [2:0] lut [16];

    logic [3:0] stim_a, stim_b, fail_vec_a, fail_vec_b;
    logic [2:0] dut_out_a, dut_out_b, max_err_a, max_err_b;
    logic [4:0] err_count_a, err_count_b;
    logic [6:0] err_sum_a, err_sum_b;
    logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b, fail_valid_a, fail_valid_b;

    assign dut_out_a = lut[stim_a];
    assign dut_out_b = lut[stim_b];

    approx_adder_et_checker #(.OP_BITS(2), .IN_BITS(4), .OUT_BITS(3), .ET(3)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stim(stim_a), .dut_out(dut_out_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .max_err(max_err_a),
        .err_count(err_count_a), .err_sum(err_sum_a), .fail_valid(fail_valid_a),
        .fail_vec(fail_vec_a)
    );

    approx_adder_et_checker #(.OP_BITS(2), .IN_BITS(4), .OUT_BITS(3), .ET(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stim(stim_b), .dut_out(dut_out_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .max_err(max_err_b),
        .err_count(err_count_b), .err_sum(err_sum_b), .fail_valid(fail_valid_b),
        .fail_vec(fail_vec_b)
    );

    int checks = 0;
    int errors = 0;

    // Observed verdict bundle: full stats of the ET=3 instance plus ET=2 verdict fields.
    function automatic logic [26:0] obs();
        return {max_err_a, err_count_a, err_sum_a, pass_a, fail_valid_a, fail_vec_a,
                pass_b, fail_valid_b, fail_vec_b};
    endfunction

    function automatic logic [26:0] pack_exp(int mx, int cnt, int sum, int pa, int fva,
                                             int fveca, int pb, int fvb, int fvecb);
        return {3'(mx), 5'(cnt), 7'(sum), 1'(pa), 1'(fva), 4'(fveca), 1'(pb), 1'(fvb),
                4'(fvecb)};
    endfunction

    // Reference: walk all operand pairs with plain integer arithmetic.
    task automatic model(output logic [26:0] e);
        int mx = 0, cnt = 0, sum = 0;
        int fv3 = 0, fvec3 = 0, fv2 = 0, fvec2 = 0;
        for (int i = 0; i < 16; i++) begin
            int d;
            d = (i % 4) + (i / 4) - int'(lut[i]);
            if (d < 0) d = -d;
            if (d > mx) mx = d;
            if (d != 0) cnt++;
            sum += d;
            if (d > 3 && fv3 == 0) begin fv3 = 1; fvec3 = i; end
            if (d > 2 && fv2 == 0) begin fv2 = 1; fvec2 = i; end
        end
        e = pack_exp(mx, cnt, sum, (mx <= 3) ? 1 : 0, fv3, fvec3, (mx <= 2) ? 1 : 0, fv2, fvec2);
    endtask

    task automatic set_lut(input int mode);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0:       lut[i] = 3'((i % 4) + (i / 4));
                1:       lut[i] = 3'd3;
                2:       lut[i] = 3'd0;
                default: lut[i] = 3'($urandom_range(0, 7));
            endcase
        end
    endtask

    // Pulses start and counts cycles from the sampling edge until done is seen.
    task automatic run_sweep(output int cycles, output bit timeout);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        while (!done_a && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        timeout = !done_a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (obs() !== 27'd0) begin
            $display("FAIL reset_stats got %h want %h", obs(), 27'd0);
            errors++;
        end
        checks++;
        if ({stim_a, busy_a, done_a, stim_b, busy_b, done_b} !== 12'd0) begin
            $display("FAIL reset_ctrl got stim=%0d busy=%b done=%b want 0 0 0",
                     stim_a, busy_a, done_a);
            errors++;
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_exact_latency();
        int cycles;
        set_lut(0);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if ({busy_a, done_a, stim_a} !== {1'b1, 1'b0, 4'd0}) begin
            $display("FAIL first_cycle got busy=%b done=%b stim=%0d want 1 0 0",
                     busy_a, done_a, stim_a);
            errors++;
        end
        @(negedge clk);
        cycles = 1;
        checks++;
        if (stim_a !== 4'd1) begin
            $display("FAIL second_vec got stim=%0d want 1", stim_a);
            errors++;
        end
        while (!done_a && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != 16) begin
            $display("FAIL exact_latency got %0d want 16", cycles);
            errors++;
        end
        checks++;
        if (obs() !== pack_exp(0, 0, 0, 1, 0, 0, 1, 0, 0)) begin
            $display("FAIL exact_stats got %h want %h", obs(), pack_exp(0, 0, 0, 1, 0, 0, 1, 0, 0));
            errors++;
        end
        @(negedge clk);
        checks++;
        if ({done_a, busy_a, stim_a, pass_a} !== {1'b0, 1'b0, 4'd15, 1'b1}) begin
            $display("FAIL done_hold got done=%b busy=%b stim=%0d pass=%b want 0 0 15 1",
                     done_a, busy_a, stim_a, pass_a);
            errors++;
        end
    endtask

    task automatic test_const3();
        int cycles;
        bit to;
        set_lut(1);
        run_sweep(cycles, to);
        checks++;
        if (to || obs() !== pack_exp(3, 12, 20, 1, 0, 0, 0, 1, 0)) begin
            $display("FAIL const3_stats got %h timeout=%b want %h", obs(), to,
                     pack_exp(3, 12, 20, 1, 0, 0, 0, 1, 0));
            errors++;
        end
    endtask

    task automatic test_stuck0();
        int cycles;
        bit to;
        set_lut(2);
        run_sweep(cycles, to);
        checks++;
        if (to || obs() !== pack_exp(6, 15, 48, 0, 1, 7, 0, 1, 3)) begin
            $display("FAIL stuck0_stats got %h timeout=%b want %h", obs(), to,
                     pack_exp(6, 15, 48, 0, 1, 7, 0, 1, 3));
            errors++;
        end
    endtask

    task automatic test_random();
        int cycles;
        bit to;
        logic [26:0] e;
        for (int n = 0; n < 4; n++) begin
            set_lut(3);
            model(e);
            run_sweep(cycles, to);
            checks++;
            if (to || cycles != 16 || obs() !== e) begin
                $display("FAIL random_%0d got %h cycles=%0d want %h cycles=16", n, obs(),
                         cycles, e);
                errors++;
            end
        end
    endtask

    task automatic test_rst_mid_sweep();
        int cycles;
        bit to;
        logic [26:0] e;
        set_lut(3);
        model(e);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({obs(), stim_a, busy_a, done_a} !== 33'd0) begin
            $display("FAIL mid_rst got stats=%h stim=%0d busy=%b done=%b want all 0", obs(),
                     stim_a, busy_a, done_a);
            errors++;
        end
        rst = 1'b0;
        run_sweep(cycles, to);
        checks++;
        if (to || cycles != 16 || obs() !== e) begin
            $display("FAIL after_rst got %h cycles=%0d want %h cycles=16", obs(), cycles, e);
            errors++;
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        set_lut(2);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cycles = 0;
        repeat (5) begin
            @(negedge clk);
            cycles++;
        end
        start = 1'b1;
        @(negedge clk);
        cycles++;
        start = 1'b0;
        while (!done_a && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != 16) begin
            $display("FAIL ignore_start got %0d want 16", cycles);
            errors++;
        end
        start = 1'b1;
        @(negedge clk);
        checks++;
        if ({done_a, busy_a, max_err_a, err_count_a, err_sum_a, fail_valid_a, pass_a}
            !== {1'b0, 1'b1, 17'd0}) begin
            $display("FAIL rearm got done=%b busy=%b max=%0d cnt=%0d sum=%0d fv=%b pass=%b",
                     done_a, busy_a, max_err_a, err_count_a, err_sum_a, fail_valid_a, pass_a);
            errors++;
        end
        start = 1'b0;
        cycles = 0;
        while (!done_a && cycles < 40) begin
            @(negedge clk);
            cycles++;
        end
        checks++;
        if (cycles != 16 || obs() !== pack_exp(6, 15, 48, 0, 1, 7, 0, 1, 3)) begin
            $display("FAIL second_sweep got %h cycles=%0d want %h cycles=16", obs(), cycles,
                     pack_exp(6, 15, 48, 0, 1, 7, 0, 1, 3));
            errors++;
        end
        @(negedge clk);
        checks++;
        if (done_a !== 1'b0) begin
            $display("FAIL done_pulse got %b want 0", done_a);
            errors++;
        end
    endtask

    initial begin
        set_lut(0);
        rst = 1'b1;
        start = 1'b0;
        test_reset();
        test_exact_latency();
        test_const3();
        test_stuck0();
        test_random();
        test_rst_mid_sweep();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
